slot_config_ctrl: RTL and testbench

Configuration controller for the MSX slot-selection datapath. It decodes Z80 bus cycles and owns the primary slot register (PPI port A, I/O 0xA8). It also owns the per-slot secondary (sub-slot) registers at memory 0xFFFF. It drives the 8-bit primary slot map and the enable flag consumed by the slot decoder. Each write bus cycle commits exactly once, under a small state machine.

---
 rtl/slot_config_ctrl.sv | 135 +++++++++++++
 tb/tb_slot_config_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : slot_config_ctrl
// Brief   : MSX slot configuration controller. Owns the primary slot register
//           (I/O PPI port A) and the per-slot sub-slot registers at 0xFFFF.
//           A small write FSM commits every write bus cycle exactly once and
//           drives the primary slot map plus the sub-slot views.
// Revision: 1.0 - initial release
// ============================================================================
module slot_config_ctrl #(
  parameter logic [7:0] PPI_PORT = 8'hA8,
  parameter logic [3:0] EXPANDED = 4'b1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        iorq_n,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfrsh_n,
  output logic [7:0]  ram_cs,
  output logic        map_valid,
  output logic [1:0]  sub_sel,
  output logic [7:0]  sub_map,
  output logic [7:0]  dout,
  output logic        dout_en
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t          r_state;
  logic [7:0]      r_prim;
  logic [3:0][7:0] r_sub;
  logic            r_map_valid;
  // Previous wr_n sample; a commit needs a high-then-low sequence.
  logic            r_wr_q;
  // Write qualifier, target and data captured when the write is accepted.
  logic            r_cap_io;
  logic [1:0]      r_cap_tgt;
  logic [7:0]      r_cap_din;

  logic            w_io_hit;
  logic            w_ss_hit;
  logic            w_wr_start;
  logic [1:0]      w_page;
  logic [1:0]      w_slot;
  logic [7:0]      w_sub_cur;
  logic [7:0]      w_sub_top;

  assign w_io_hit   = ~iorq_n & (addr[7:0] == PPI_PORT);
  assign w_ss_hit   = ~mreq_n & rfrsh_n & (addr == 16'hFFFF) & EXPANDED[r_prim[7:6]];
  assign w_wr_start = ~wr_n & r_wr_q & (w_io_hit | w_ss_hit);

  // Write FSM: accept on a falling wr_n sample, commit one cycle later, then
  // wait for wr_n to return high so a long strobe commits only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prim      <= 8'h00;
      r_sub       <= '0;
      r_map_valid <= 1'b0;
      r_wr_q      <= 1'b0;
      r_cap_io    <= 1'b0;
      r_cap_tgt   <= 2'b00;
      r_cap_din   <= 8'h00;
    end else begin
      r_wr_q <= wr_n;
      case (r_state)
        S_IDLE: begin
          if (w_wr_start) begin
            r_cap_io  <= w_io_hit;
            r_cap_tgt <= r_prim[7:6];
            r_cap_din <= din;
            r_state   <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (r_cap_io) begin
            r_prim      <= r_cap_din;
            r_map_valid <= 1'b1;
          end else begin
            r_sub[r_cap_tgt] <= r_cap_din;
          end
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (wr_n) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_cs    = r_prim;
  assign map_valid = r_map_valid;

  // Sub-slot view of the page currently addressed on the bus.
  assign w_page    = addr[15:14];
  assign w_slot    = r_prim[{w_page, 1'b0} +: 2];
  assign w_sub_cur = r_sub[w_slot];
  assign w_sub_top = r_sub[r_prim[7:6]];

  // Sub-slot outputs are zero whenever the mapped slot is not expanded.
  always_comb begin
    sub_sel = 2'b00;
    sub_map = 8'h00;
    if (EXPANDED[w_slot]) begin
      sub_sel = w_sub_cur[{w_page, 1'b0} +: 2];
      sub_map = w_sub_cur;
    end
  end

  // Read-back mux; the sub-slot register reads back inverted as on real MSX.
  always_comb begin
    dout    = 8'hFF;
    dout_en = 1'b0;
    if (w_io_hit & ~rd_n) begin
      dout    = r_prim;
      dout_en = 1'b1;
    end else if (w_ss_hit & ~rd_n) begin
      dout    = ~w_sub_top;
      dout_en = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slot_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_slot_config_ctrl
// Brief   : Self-checking bench for slot_config_ctrl: directed scenarios with
//           literal expectations followed by randomized bus cycles compared
//           every cycle against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_slot_config_ctrl;

  localparam logic [3:0] EXP = 4'b1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        iorq_n, mreq_n, rd_n, wr_n, rfrsh_n;
  logic [7:0]  ram_cs;
  logic        map_valid;
  logic [1:0]  sub_sel;
  logic [7:0]  sub_map;
  logic [7:0]  dout;
  logic        dout_en;

  int n_checks = 0;
  int n_errors = 0;

  slot_config_ctrl #(.PPI_PORT(8'hA8), .EXPANDED(EXP)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din),
    .iorq_n(iorq_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .rfrsh_n(rfrsh_n),
    .ram_cs(ram_cs), .map_valid(map_valid), .sub_sel(sub_sel), .sub_map(sub_map),
    .dout(dout), .dout_en(dout_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Architectural state plus one scheduled commit: a write seen on a falling
  // wr_n sample lands in the registers one clock later.
  logic [7:0] m_prim;
  logic [7:0] m_sub [4];
  logic       m_valid;
  logic       m_prev_wr;
  logic       m_pend;
  logic       m_pend_io;
  logic [1:0] m_pend_tgt;
  logic [7:0] m_pend_din;

  function automatic logic m_io();
    return !iorq_n && (addr[7:0] == 8'hA8);
  endfunction

  function automatic logic m_ss();
    return !mreq_n && rfrsh_n && (addr == 16'hFFFF) && EXP[m_prim[7:6]];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prim <= 8'h00;
      for (int i = 0; i < 4; i++) m_sub[i] <= 8'h00;
      m_valid   <= 1'b0;
      m_prev_wr <= 1'b0;
      m_pend    <= 1'b0;
    end else begin
      m_prev_wr <= wr_n;
      m_pend    <= 1'b0;
      if (m_pend) begin
        if (m_pend_io) begin
          m_prim  <= m_pend_din;
          m_valid <= 1'b1;
        end else begin
          m_sub[m_pend_tgt] <= m_pend_din;
        end
      end
      if (!wr_n && m_prev_wr && !m_pend && (m_io() || m_ss())) begin
        m_pend     <= 1'b1;
        m_pend_io  <= m_io();
        m_pend_tgt <= m_prim[7:6];
        m_pend_din <= din;
      end
    end
  end

  // Expected outputs derived from model state and the current bus.
  logic [1:0] e_pg, e_slot, e_sel;
  logic [7:0] e_map, e_dout;
  logic       e_en;

  always @(negedge clk) begin
    e_pg   = addr[15:14];
    e_slot = 2'((m_prim >> (2 * e_pg)) & 8'h03);
    e_map  = EXP[e_slot] ? m_sub[e_slot] : 8'h00;
    e_sel  = EXP[e_slot] ? 2'((m_sub[e_slot] >> (2 * e_pg)) & 8'h03) : 2'b00;
    if (m_io() && !rd_n) begin
      e_dout = m_prim; e_en = 1'b1;
    end else if (m_ss() && !rd_n) begin
      e_dout = ~m_sub[m_prim[7:6]]; e_en = 1'b1;
    end else begin
      e_dout = 8'hFF; e_en = 1'b0;
    end
    chk("ram_cs", ram_cs, m_prim);
    chk("map_valid", {7'd0, map_valid}, {7'd0, m_valid});
    chk("sub_sel", {6'd0, sub_sel}, {6'd0, e_sel});
    chk("sub_map", sub_map, e_map);
    chk("dout", dout, e_dout);
    chk("dout_en", {7'd0, dout_en}, {7'd0, e_en});
  end

  // ---------------- stimulus ----------------
  task automatic release_bus();
    iorq_n = 1'b1; mreq_n = 1'b1; rfrsh_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
  endtask

  // One bus cycle: strobe low for 'hold' clock samples, then high for 'gap'.
  task automatic bus(input logic io, input logic wr, input logic rf,
                     input logic [15:0] a, input logic [7:0] d,
                     input int hold, input int gap);
    @(posedge clk); #2;
    addr = a; din = d;
    if (io) iorq_n = 1'b0;
    else begin
      mreq_n  = 1'b0;
      rfrsh_n = rf ? 1'b0 : 1'b1;
    end
    if (wr) wr_n = 1'b0; else rd_n = 1'b0;
    repeat (hold) @(posedge clk);
    #2; release_bus();
    repeat (gap) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; addr = 16'h0000; din = 8'h00;
    release_bus();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_ram_cs", ram_cs, 8'h00);
    chk("rst_map_valid", {7'd0, map_valid}, 8'h00);
    chk("rst_dout_en", {7'd0, dout_en}, 8'h00);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_sub_map", sub_map, 8'h00);

    // First primary write: still old after the sampling edge, new one edge later.
    bus(1'b1, 1'b1, 1'b0, 16'h00A8, 8'hE4, 1, 0);
    chk("lat_before", ram_cs, 8'h00);
    @(posedge clk); #1;
    chk("lat_ram_cs", ram_cs, 8'hE4);
    chk("lat_map_valid", {7'd0, map_valid}, 8'h01);

    // Long strobes.
    bus(1'b1, 1'b1, 1'b0, 16'h12A8, 8'h55, 10, 2);
    chk("long_55", ram_cs, 8'h55);
    bus(1'b1, 1'b1, 1'b0, 16'h00A8, 8'hAA, 10, 2);
    chk("long_AA", ram_cs, 8'hAA);

    // Expanded slot 3 in page 3 (and page 1) -> sub-slot register write.
    bus(1'b1, 1'b1, 1'b0, 16'h00A8, 8'hCC, 1, 2);
    bus(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h1B, 2, 2);
    addr = 16'h4000; #1;
    chk("sub_sel_p1", {6'd0, sub_sel}, 8'h02);
    chk("sub_map_p1", sub_map, 8'h1B);
    addr = 16'h0000; #1;
    chk("sub_sel_p0", {6'd0, sub_sel}, 8'h00);
    addr = 16'hFFFF; mreq_n = 1'b0; rd_n = 1'b0; #1;
    chk("rd_ffff", dout, 8'hE4);
    chk("rd_ffff_en", {7'd0, dout_en}, 8'h01);
    release_bus();

    // Page 3 in non-expanded slot 0: no sub-slot register visible or writable.
    bus(1'b1, 1'b1, 1'b0, 16'h00A8, 8'h00, 1, 2);
    bus(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h33, 2, 2);
    addr = 16'hFFFF; mreq_n = 1'b0; rd_n = 1'b0; #1;
    chk("rd_nonexp_en", {7'd0, dout_en}, 8'h00);
    release_bus();
    for (int p = 0; p < 4; p++) begin
      addr = 16'(p) << 14; #1;
      chk("nonexp_sub_sel", {6'd0, sub_sel}, 8'h00);
    end
    bus(1'b1, 1'b1, 1'b0, 16'h00A8, 8'hC0, 1, 2);
    addr = 16'hFFFF; #1;
    chk("sub3_kept", sub_map, 8'h1B);

    // Refresh cycle must not write the sub-slot register.
    bus(1'b0, 1'b1, 1'b1, 16'hFFFF, 8'h77, 2, 2);
    chk("rfsh_nowrite", sub_map, 8'h1B);

    // Reset while in HOLD, released with wr_n still low: no commit afterwards.
    @(posedge clk); #2;
    addr = 16'h00A8; din = 8'h99; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_hold_ram_cs", ram_cs, 8'h00);
    chk("rst_hold_valid", {7'd0, map_valid}, 8'h00);
    chk("rst_hold_dout_en", {7'd0, dout_en}, 8'h00);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 release_bus();
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ram_cs", ram_cs, 8'h00);
    chk("post_rst_valid", {7'd0, map_valid}, 8'h00);

    // Randomized bus traffic checked by the model every cycle.
    for (int t = 0; t < 400; t++) begin
      int kind;
      int hold;
      int gap;
      logic [7:0] d;
      logic [15:0] a;
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 4));
      gap  = int'($urandom_range(1, 3));
      d    = 8'($urandom);
      a    = 16'($urandom);
      case (kind)
        0, 1: bus(1'b1, 1'b1, 1'b0, {a[15:8], 8'hA8}, d, hold, gap);
        2, 3: bus(1'b0, 1'b1, 1'b0, 16'hFFFF, d, hold, gap);
        4:    bus(1'b0, 1'b1, 1'b1, 16'hFFFF, d, hold, gap);
        5:    bus(1'b1, 1'b1, 1'b0, a, d, hold, gap);
        6:    bus(1'b1, 1'b0, 1'b0, {a[15:8], 8'hA8}, d, hold, gap);
        7:    bus(1'b0, 1'b0, 1'b0, (a[0] ? 16'hFFFF : a), d, hold, gap);
        8:    bus(1'b0, 1'b1, 1'b0, a, d, hold, gap);
        default: begin
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #2;
            addr = {a[15:8], 8'hA8}; din = d; iorq_n = 1'b0; wr_n = 1'b0;
            repeat (hold) @(posedge clk);
            #2 reset = 1'b1;
            #1 chk("rnd_rst_ram_cs", ram_cs, 8'h00);
            repeat (2) @(posedge clk);
            #2 reset = 1'b0;
            repeat (gap) @(posedge clk);
            #2 release_bus();
            repeat (2) @(posedge clk);
          end else begin
            @(posedge clk); #2 addr = a;
            repeat (gap) @(posedge clk);
          end
        end
      endcase
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
